// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types: word size, round count, controller states,
// initial chaining value and the round-constant table.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [255:0] H0_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_word(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

endpackage

// File: rtl/sha256_round_state.sv
// SHA-256 working-variable bank and round sequencer: loads the chaining value,
// absorbs T1/T2 for ROUNDS rounds, then adds the feed-forward into the digest.
module sha256_round_state #(
  parameter int ROUNDS = sha256_pkg::ROUNDS,
  parameter int WORD_W = sha256_pkg::WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*WORD_W-1:0] hash_in,
  input  logic [WORD_W-1:0]   t1,
  input  logic [WORD_W-1:0]   t2,
  output logic [WORD_W-1:0]   a_out,
  output logic [WORD_W-1:0]   b_out,
  output logic [WORD_W-1:0]   c_out,
  output logic [WORD_W-1:0]   d_out,
  output logic [WORD_W-1:0]   e_out,
  output logic [WORD_W-1:0]   f_out,
  output logic [WORD_W-1:0]   g_out,
  output logic [WORD_W-1:0]   h_out,
  output logic [5:0]          round_idx,
  output logic                busy,
  output logic [8*WORD_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ack
);
  import sha256_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t              state_r;
  logic [WORD_W-1:0]   work_r  [8];
  logic [WORD_W-1:0]   saved_r [8];
  logic [8*WORD_W-1:0] digest_r;
  logic [8*WORD_W-1:0] sum_s;
  logic [5:0]          round_r;
  logic                busy_r;
  logic                valid_r;

  assign a_out        = work_r[0];
  assign b_out        = work_r[1];
  assign c_out        = work_r[2];
  assign d_out        = work_r[3];
  assign e_out        = work_r[4];
  assign f_out        = work_r[5];
  assign g_out        = work_r[6];
  assign h_out        = work_r[7];
  assign round_idx    = round_r;
  assign busy         = busy_r;
  assign digest       = digest_r;
  assign digest_valid = valid_r;

  // Feed-forward: word 0 (a) lands in the most significant digest word.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < 8; i++) begin
      sum_s[(7-i)*WORD_W +: WORD_W] = saved_r[i] + work_r[i];
    end
  end

  // Controller and register bank; only IDLE honours start, only DONE honours ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      digest_r <= '0;
      round_r  <= 6'd0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work_r[i]  <= '0;
        saved_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              work_r[i]  <= hash_in[(7-i)*WORD_W +: WORD_W];
              saved_r[i] <= hash_in[(7-i)*WORD_W +: WORD_W];
            end
            round_r <= 6'd0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          work_r[0] <= t1 + t2;
          work_r[1] <= work_r[0];
          work_r[2] <= work_r[1];
          work_r[3] <= work_r[2];
          work_r[4] <= work_r[3] + t1;
          work_r[5] <= work_r[4];
          work_r[6] <= work_r[5];
          work_r[7] <= work_r[6];
          if (round_r == LAST_IDX) begin
            round_r <= 6'd0;
            state_r <= ADD;
          end else begin
            round_r <= round_r + 6'd1;
          end
        end
        ADD: begin
          digest_r <= sum_s;
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= DONE;
        end
        DONE: begin
          if (digest_ack) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          round_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_state.sv
// Self-checking bench for sha256_round_state: stub vectors, randomized rounds
// against a behavioural model, control corner cases and a full "abc" hash.
module tb_sha256_round_state;
  import sha256_pkg::*;

  localparam logic [255:0] ABC_DIGEST = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  typedef struct {
    logic [255:0] hash;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         digest_ack = 1'b0;
  logic [255:0] hash_in = '0;
  logic [31:0]  t1, t2;
  logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
  logic [5:0]   round_idx;
  logic         busy, digest_valid;
  logic [255:0] digest;

  logic         sha_mode = 1'b0;
  logic [31:0]  stub_t1 = '0;
  logic [31:0]  stub_t2 = '0;
  logic [31:0]  w_sched [64];
  int           n_checks = 0;
  int           n_fails = 0;

  sha256_round_state dut (
    .clk(clk), .rst(rst), .start(start), .hash_in(hash_in), .t1(t1), .t2(t2),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .e_out(e_out), .f_out(f_out), .g_out(g_out), .h_out(h_out),
    .round_idx(round_idx), .busy(busy), .digest(digest),
    .digest_valid(digest_valid), .digest_ack(digest_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Environment: either stub T1/T2 or real SHA-256 T1/T2 computed from the bank.
  always_comb begin
    if (sha_mode) begin
      t1 = h_out + big_s1(e_out) + ((e_out & f_out) ^ (~e_out & g_out))
           + k_word(round_idx) + w_sched[round_idx];
      t2 = big_s0(a_out) + ((a_out & b_out) ^ (a_out & c_out) ^ (b_out & c_out));
    end else begin
      t1 = stub_t1;
      t2 = stub_t2;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bank();
    return {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};
  endfunction

  // Pulse start, then wait (bounded) for digest_valid; lat counts edges after the start edge.
  task automatic run_block(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!digest_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_block(input string name);
    digest_ack = 1'b1;
    @(negedge clk);
    digest_ack = 1'b0;
    check(name, 256'({busy, digest_valid}), 256'(0));
  endtask

  task automatic random_block(input int id);
    logic [31:0]  v [8];
    logic [31:0]  hw [8];
    logic [31:0]  r1, r2, old_d;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) begin
      hw[i] = $urandom;
      v[i]  = hw[i];
      hash_in[(7-i)*32 +: 32] = hw[i];
    end
    sha_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      check($sformatf("rand%0d_idx%0d", id, r), 256'(round_idx), 256'(r));
      r1 = $urandom;
      r2 = $urandom;
      stub_t1 = r1;
      stub_t2 = r2;
      digest_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      old_d = v[3];
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[0] = r1 + r2;
      v[4] = old_d + r1;
      check($sformatf("rand%0d_bank%0d", id, r), bank(), {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]});
    end
    digest_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp[(7-i)*32 +: 32] = hw[i] + v[i];
    check($sformatf("rand%0d_valid", id), 256'(digest_valid), 256'(1));
    check($sformatf("rand%0d_digest", id), digest, exp);
    ack_block($sformatf("rand%0d_ack", id));
  endtask

  initial begin
    vec_t         vecs [5];
    logic [31:0]  blk [16];
    int           lat, busy_cnt, idx_err;

    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w_sched[i] = blk[i];
      else w_sched[i] = small_s1(w_sched[i-2]) + w_sched[i-7] + small_s0(w_sched[i-15]) + w_sched[i-16];
    end

    vecs[0] = '{256'h0, 32'd0, 32'd0, 256'h0};
    vecs[1] = '{{8{32'hffffffff}}, 32'd1, 32'd0, {{4{32'h0}}, {4{32'h1}}}};
    vecs[2] = '{256'h0, 32'd0, 32'd5, {8{32'h5}}};
    vecs[3] = '{H0_INIT, 32'd0, 32'd0, H0_INIT};
    vecs[4] = '{256'h0, 32'd3, 32'd4, {{4{32'h7}}, {4{32'ha}}}};

    repeat (2) @(negedge clk);
    check("reset_bank", bank(), 256'h0);
    check("reset_digest", digest, 256'h0);
    check("reset_ctrl", 256'({round_idx, busy, digest_valid}), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      hash_in = vecs[i].hash;
      stub_t1 = vecs[i].t1;
      stub_t2 = vecs[i].t2;
      run_block(lat);
      check($sformatf("vec%0d_latency", i), 256'(lat), 256'(ROUNDS + 1));
      check($sformatf("vec%0d_digest", i), digest, vecs[i].exp);
      ack_block($sformatf("vec%0d_ack", i));
    end

    // Zero block: busy window, round_idx stepping and valid timing.
    hash_in = '0;
    stub_t1 = '0;
    stub_t2 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    idx_err = 0;
    for (int c = 1; c <= ROUNDS + 2; c++) begin
      if (busy) busy_cnt++;
      if (round_idx != ((c <= ROUNDS) ? 6'(c - 1) : 6'd0)) idx_err++;
      if (digest_valid != (c == ROUNDS + 2)) idx_err++;
      if (c < ROUNDS + 2) @(negedge clk);
    end
    check("busy_cycles", 256'(busy_cnt), 256'(ROUNDS + 1));
    check("round_idx_sequence", 256'(idx_err), 256'(0));
    check("zero_digest", digest, 256'h0);

    // start in DONE is ignored, ack held low keeps the digest stable.
    hash_in = {8{32'hffffffff}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", 256'({busy, digest_valid}), 256'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d", c), {digest[254:0], digest_valid}, 256'(1));
    end
    start = 1'b1;
    digest_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    digest_ack = 1'b0;
    check("ack_with_start", 256'({busy, digest_valid}), 256'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("idle_after_ack%0d", c), 256'({busy, digest_valid, round_idx}), 256'(0));
    end
    check("digest_kept_after_ack", digest, 256'h0);

    // start during RUN is ignored.
    hash_in = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    hash_in = {8{32'hffffffff}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_start_ignored", 256'({busy, round_idx}), 256'({1'b1, 6'd11}));
    lat = 0;
    while (!digest_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("run_start_latency", 256'(lat), 256'(ROUNDS + 1 - 11));
    check("run_start_digest", digest, 256'h0);
    ack_block("run_start_ack");

    for (int b = 0; b < 3; b++) random_block(b);

    // Real SHA-256 "abc": abandon at round 30 with an asynchronous reset, then rerun.
    sha_mode = 1'b1;
    hash_in = H0_INIT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_idx", 256'(round_idx), 256'(30));
    #2 rst = 1'b0;
    #1;
    check("async_reset_bank", bank(), 256'h0);
    check("async_reset_digest", digest, 256'h0);
    check("async_reset_ctrl", 256'({round_idx, busy, digest_valid}), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_block(lat);
    check("abc_latency", 256'(lat), 256'(ROUNDS + 1));
    check("abc_digest", digest, ABC_DIGEST);
    ack_block("abc_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
